// File: rtl/i2c_write_master.sv
// Purpose: byte-level I2C write engine; sends START, device address, register, data, STOP.
// Latency: accept edge to ready_out=1 is 1 + 29*4*DIV_Q + 1 cycles (fewer when a byte is NACKed).
// Backpressure: start is sampled only while ready_out=1; requests made while busy are dropped.
//
// Ports:
//   clk_in     single clock for the whole block
//   reset      synchronous, active-high reset; releases the bus immediately
//   start      transaction request, level-sampled while ready_out=1
//   dev_addr   device write address (bit0 sent as-is)
//   reg_data   [15:8] register address, [7:0] register value
//   ready_out  idle and able to accept start
//   ack        1 = all three bytes ACKed on the last transaction, 0 = NACK seen
//   states     debug: [7:5] FSM code, [4:0] bit/ack slot index
//   i2c_sda    open-drain data line: driven 0 or released
//   i2c_scl    push-pull clock line, no clock stretching
module i2c_write_master #(
    parameter int DIV_Q = 125
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  dev_addr,
    input  logic [15:0] reg_data,
    output logic        ready_out,
    output logic        ack,
    output logic [7:0]  states,
    inout  wire         i2c_sda,
    output logic        i2c_scl
);

    localparam int CW = (DIV_Q > 1) ? $clog2(DIV_Q) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACKS  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [CW-1:0] ph_cnt;     // clk_in cycles inside the current quarter-bit phase
    logic [1:0]  quarter;      // p0..p3 inside the current slot
    logic [4:0]  slot_idx;     // 0..26 across all bit and ack slots
    logic [23:0] shreg;        // {dev_addr, reg_addr, reg_val}, MSB on the wire
    logic        nack;
    logic        sda_low;

    logic q_end;
    logic slot_end;
    logic slot_run;
    logic accept;
    logic last_bit;

    assign q_end    = (ph_cnt == CW'(DIV_Q - 1));
    assign slot_end = q_end && (quarter == 2'd3);
    assign slot_run = (state == ST_START) || (state == ST_BIT) ||
                      (state == ST_ACKS)  || (state == ST_STOP);
    assign accept   = ready_out && start;
    // Slot indices of the 8th bit of each byte; an ack slot follows each one.
    assign last_bit = (slot_idx == 5'd7) || (slot_idx == 5'd16) || (slot_idx == 5'd25);

    // Open drain: never drive a 1 onto SDA.
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    // State register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. IDLE with ready_out=0 is the single load cycle that
    // follows an accept; the slot engine starts on the cycle after it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!ready_out) state_nxt = ST_START;
            ST_START: if (slot_end) state_nxt = ST_BIT;
            ST_BIT:   if (slot_end) state_nxt = last_bit ? ST_ACKS : ST_BIT;
            ST_ACKS:  if (slot_end) state_nxt = (nack || slot_idx == 5'd26) ? ST_STOP : ST_BIT;
            ST_STOP:  if (slot_end) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Bus waveform per slot and quarter
    always_comb begin
        i2c_scl = 1'b1;
        sda_low = 1'b0;
        case (state)
            ST_START: begin
                i2c_scl = (quarter != 2'd3);
                sda_low = (quarter >= 2'd2);
            end
            ST_BIT: begin
                i2c_scl = (quarter == 2'd1) || (quarter == 2'd2);
                sda_low = ~shreg[23];
            end
            ST_ACKS: begin
                i2c_scl = (quarter == 2'd1) || (quarter == 2'd2);
                sda_low = 1'b0;
            end
            ST_STOP: begin
                i2c_scl = (quarter != 2'd0);
                sda_low = (quarter <= 2'd1);
            end
            default: begin
                i2c_scl = 1'b1;
                sda_low = 1'b0;
            end
        endcase
        states = {state, slot_idx};
    end

    // Datapath: phase timing, shift register, slot index, ack result
    always_ff @(posedge clk_in) begin
        if (reset) begin
            ph_cnt    <= '0;
            quarter   <= 2'd0;
            slot_idx  <= 5'd0;
            shreg     <= 24'd0;
            nack      <= 1'b0;
            ready_out <= 1'b1;
            ack       <= 1'b0;
        end else begin
            if (slot_run) begin
                if (q_end) begin
                    ph_cnt  <= '0;
                    quarter <= quarter + 2'd1;
                end else begin
                    ph_cnt <= ph_cnt + CW'(1);
                end
            end else begin
                ph_cnt  <= '0;
                quarter <= 2'd0;
            end

            if (accept) begin
                shreg     <= {dev_addr, reg_data};
                nack      <= 1'b0;
                ready_out <= 1'b0;
            end else if (state == ST_BIT && slot_end) begin
                shreg <= {shreg[22:0], 1'b0};
            end

            // Slave response is taken at the end of the SCL-high window.
            if (state == ST_ACKS && quarter == 2'd2 && q_end && i2c_sda) begin
                nack <= 1'b1;
            end

            if ((state == ST_BIT || state == ST_ACKS) && slot_end) begin
                slot_idx <= (state_nxt == ST_STOP) ? 5'd0 : slot_idx + 5'd1;
            end

            // ack and ready_out publish together so ack is valid whenever ready_out=1.
            if (state == ST_DONE) begin
                ack       <= ~nack;
                ready_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
module tb_i2c_write_master;

    localparam int D       = 2;
    localparam int LAT_ALL = 1 + 29*4*D + 1;   // 234
    localparam int LAT_A   = 1 + 11*4*D + 1;   // 90
    localparam int LAT_R   = 1 + 20*4*D + 1;   // 162

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  dev_addr;
    logic [15:0] reg_data;
    logic        ready_out;
    logic        ack;
    logic [7:0]  states;
    logic        scl;
    wire         sda;

    pullup pu_sda (sda);

    i2c_write_master #(.DIV_Q(D)) dut (
        .clk_in    (clk),
        .reset     (reset),
        .start     (start),
        .dev_addr  (dev_addr),
        .reg_data  (reg_data),
        .ready_out (ready_out),
        .ack       (ack),
        .states    (states),
        .i2c_sda   (sda),
        .i2c_scl   (scl)
    );

    always #5 clk = ~clk;

    // ---------------- slave model and bus monitor ----------------
    logic       ack_drv = 1'b0;
    logic [2:0] nack_mask = 3'b000;   // bit b set: slave NACKs byte b
    logic       mon_en = 1'b0;
    logic       scl_q = 1'b1;
    logic       sda_q = 1'b1;
    logic [7:0] sh = 8'd0;
    logic [7:0] rx [0:2];
    int         bitn = 0;
    int         byten = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         rise_cnt = 0;
    int         x_cnt = 0;

    assign sda = ack_drv ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        if (mon_en && sda !== 1'b0 && sda !== 1'b1) x_cnt++;
        if (reset) begin
            bitn    = 0;
            byten   = 0;
            ack_drv = 1'b0;
        end else if (mon_en) begin
            if (scl_q && scl && sda_q && !sda) begin
                start_cnt++;
                bitn  = 0;
                byten = 0;
            end else if (scl_q && scl && !sda_q && sda) begin
                stop_cnt++;
            end else if (!scl_q && scl) begin
                rise_cnt++;
                if (bitn < 8) begin
                    sh = {sh[6:0], sda};
                    bitn++;
                    if (bitn == 8 && byten < 3) rx[byten] = sh;
                end else begin
                    bitn = 0;
                    byten++;
                end
            end else if (scl_q && !scl) begin
                ack_drv = (bitn == 8 && byten < 3) ? ~nack_mask[byten] : 1'b0;
            end
        end
        scl_q = scl;
        sda_q = sda;
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int lat0, output int lat);
        lat = lat0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready_out && lat < 2000);
        if (!ready_out) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: ready_out still 0 after %0d cycles, expected 1", lat);
        end
    endtask

    task automatic accept(input logic [7:0] a, input logic [15:0] d, input logic [2:0] m);
        @(negedge clk);
        dev_addr  = a;
        reg_data  = d;
        nack_mask = m;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", ready_out, 0);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [2:0]  mask;
        logic        exp_ack;
        int          exp_lat;
        int          exp_nb;
    } vec_t;

    vec_t       vecs [0:4];
    logic [7:0] eb [0:2];
    int         s0, p0, r0, lat;
    logic       quiet;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h72, 16'h9803, 3'b000, 1'b1, LAT_ALL, 3};
        vecs[1] = '{8'h72, 16'h9803, 3'b001, 1'b0, LAT_A,   1};
        vecs[2] = '{8'h72, 16'h9803, 3'b100, 1'b0, LAT_ALL, 3};
        vecs[3] = '{8'h72, 16'h1A55, 3'b010, 1'b0, LAT_R,   2};
        vecs[4] = '{8'hA5, 16'hFF00, 3'b000, 1'b1, LAT_ALL, 3};

        reset = 1'b1; start = 1'b0; dev_addr = 8'h00; reg_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_out, 1);
        check("rst_ack", ack, 0);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_states", states, 0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven transactions with different slave responses
        for (int i = 0; i < 5; i++) begin
            s0 = start_cnt; p0 = stop_cnt; r0 = rise_cnt;
            eb[0] = vecs[i].addr; eb[1] = vecs[i].data[15:8]; eb[2] = vecs[i].data[7:0];
            accept(vecs[i].addr, vecs[i].data, vecs[i].mask);
            wait_ready(0, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_ack", i), ack, vecs[i].exp_ack);
            check($sformatf("v%0d_bytes", i), byten, vecs[i].exp_nb);
            for (int j = 0; j < vecs[i].exp_nb; j++)
                check($sformatf("v%0d_byte%0d", i, j), rx[j], eb[j]);
            check($sformatf("v%0d_starts", i), start_cnt - s0, 1);
            check($sformatf("v%0d_stops", i), stop_cnt - p0, 1);
            check($sformatf("v%0d_scl_pulses", i), rise_cnt - r0, 9*vecs[i].exp_nb + 1);
        end

        // Reset at slot 10, p2: bus released at once, no STOP slot afterwards
        accept(8'h72, 16'h9803, 3'b000);
        repeat (93) @(posedge clk);
        #1;
        check("abort_states", states, {3'd2, 5'd10});
        check("abort_scl_p2", scl, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda", sda, 1);
        check("abort_ready", ready_out, 1);
        check("abort_ack", ack, 0);
        check("abort_states_idle", states, 0);
        reset = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (scl !== 1'b1 || sda !== 1'b1 || ready_out !== 1'b1) quiet = 1'b0;
        end
        check("abort_bus_idle", quiet, 1);

        // Normal transaction after the abort
        s0 = start_cnt; p0 = stop_cnt;
        accept(8'h72, 16'h9803, 3'b000);
        wait_ready(0, lat);
        check("post_abort_latency", lat, LAT_ALL);
        check("post_abort_ack", ack, 1);
        check("post_abort_byte2", rx[2], 8'h03);
        check("post_abort_starts", start_cnt - s0, 1);
        check("post_abort_stops", stop_cnt - p0, 1);

        // start held high: back-to-back transactions, ready_out high one cycle each
        s0 = start_cnt; p0 = stop_cnt;
        @(negedge clk);
        dev_addr = 8'h72; reg_data = 16'h9803; nack_mask = 3'b000; start = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(0, lat);
        check("b2b_latency1", lat, LAT_ALL);
        @(posedge clk);
        #1;
        check("b2b_ready_one_cycle", ready_out, 0);
        wait_ready(0, lat);
        start = 1'b0;
        check("b2b_latency2", lat, LAT_ALL);
        check("b2b_ack", ack, 1);
        check("b2b_starts", start_cnt - s0, 2);
        check("b2b_stops", stop_cnt - p0, 2);

        // start pulsed while busy with different data: ignored
        s0 = start_cnt;
        accept(8'h72, 16'h9803, 3'b000);
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (k == 30) begin
                start = 1'b1; dev_addr = 8'h11; reg_data = 16'h2222;
            end
            if (k == 31) start = 1'b0;
        end
        wait_ready(lat, lat);
        check("busy_pulse_latency", lat, LAT_ALL);
        check("busy_pulse_byte0", rx[0], 8'h72);
        check("busy_pulse_byte1", rx[1], 8'h98);
        check("busy_pulse_byte2", rx[2], 8'h03);
        repeat (5) @(posedge clk);
        #1;
        check("busy_pulse_still_idle", ready_out, 1);
        check("busy_pulse_starts", start_cnt - s0, 1);

        check("sda_never_conflict", x_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
Byte-level I2C write engine. It consumes the start, dev_addr and reg_data requests issued by the HDMI init sequencer, and emits one 3-byte write transaction: START, device address, register, data, STOP. It returns a ready/ack handshake so the sequencer can advance or retry. It sits between the init sequencer and the HDMI transmitter's I2C pins.

Parameters:
DIV_Q, 125, clk_in cycles per quarter-bit phase (minimum 1); 50 MHz / (4*125) = 100 kHz SCL.

Ports:
clk_in  input  1  single clock for the whole block.
reset  input  1  synchronous, active-high reset.
start  input  1  transaction request; level-sampled.
dev_addr  input  8  device write address; bit0 is sent as-is (0x72 for HDMI TX).
reg_data  input  16  [15:8] register address, [7:0] register value.
ready_out  output  1  high when idle and able to accept start.
ack  output  1  result of last transaction: 1 = all three bytes ACKed, 0 = NACK.
states  output  8  debug: [7:5] FSM code, [4:0] slot index.
i2c_sda  inout  1  open-drain: driven 0 or released (Z), never driven 1.
i2c_scl  output  1  push-pull; no clock-stretching support.

Behaviour:
- Reset (sync, active-high) values: ready_out=1, ack=0, i2c_scl=1, i2c_sda=Z, states=0, FSM=IDLE, counters 0.
- Reset mid-transaction: bus released on that edge (SCL=1, SDA=Z). No STOP is generated. ready_out=1 the next cycle.
- Accept: at a posedge with ready_out=1 and start=1, latch {dev_addr, reg_data} into a 24-bit shift register. ready_out=0 from the next cycle.
- start is ignored while ready_out=0. If start is still high when ready_out returns to 1, a new transaction is accepted on that edge.
- Timing base: phase counter counts 0..DIV_Q-1. Each slot = 4 phases (p0..p3) = 4*DIV_Q cycles.
- FSM codes: IDLE=0, START=1, BIT=2, ACKS=3, STOP=4, DONE=5.
- START slot: p0/p1 SDA=Z, SCL=1; p2 SDA=0, SCL=1; p3 SDA=0, SCL=0.
- BIT slot, 8 per byte, MSB first:
  - p0 SCL=0, SDA = shift MSB (0, or Z for 1).
  - p1/p2 SCL=1.
  - p3 SCL=0.
  - Shift occurs at end of p3.
- ACKS slot, after every 8th bit: SDA=Z; SCL pattern same as BIT.
  - i2c_sda is sampled on the last cycle of p2.
  - Sample 0 = ACK: go to the next byte or to STOP.
  - Sample 1 = NACK: set internal nack flag and go directly to STOP.
- STOP slot: p0 SDA=0, SCL=0; p1 SDA=0, SCL=1; p2/p3 SDA=Z, SCL=1.
- DONE (1 cycle): ack = ~nack flag, ready_out=1 on the following cycle. ack and ready_out update together, so ack is valid whenever ready_out=1. ack holds until the next DONE.
- Full transaction latency, accept edge to ready_out=1: 1 + 29*4*DIV_Q + 1 cycles (START + 27 bit/ack slots + STOP).
- NACK on address byte: 1 + 11*4*DIV_Q + 1 cycles. NACK on register byte: 1 + 20*4*DIV_Q + 1 cycles.
- Slot index (states[4:0]) counts 0..26 over bit/ack slots and wraps to 0 at STOP.
- SDA transitions only while SCL=0, except the START/STOP edges.

Test Plan:
- DIV_Q=2, slave model ACKs all; dev_addr=0x72, reg_data=0x9803 -> SDA bit stream 01110010 A 10011000 A 00000011 A; ack=1; ready_out high exactly 1+232+1 cycles after accept.
- Slave NACKs the address byte -> STOP immediately after the 9th bit slot; ack=0; ready_out returns after 1+88+1 cycles; register/data bits are never driven.
- Slave NACKs only the data byte -> all 27 slots are sent; ack=0.
- Reset asserted at slot 10, p2 -> next cycle SCL=1, SDA=Z, ready_out=1, ack=0, no STOP pattern. A following start with all ACKs completes normally with ack=1.
- start held high continuously, all ACKs -> back-to-back transactions; each reaches ready_out=1 for exactly one cycle before the next accept.
- start pulsed while busy -> ignored; transaction count and data unchanged. Checker asserts SDA never driven to 1 and SDA changes only while SCL=0 outside START/STOP.
